// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer that runs a WIDTH-bit add one nibble per clock on a shared external 4-bit adder slice.
// Define ALU_SUB_EN to add the sub port and A + ~B + 1 subtraction.
module nibble_serial_add_ctrl #(
   parameter int WIDTH = 32,
   parameter int NIB   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ALU_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [NIB-1:0]   add_a,
   output logic [NIB-1:0]   add_b,
   output logic             add_cin,
   input  logic [NIB-1:0]   add_sum,
   input  logic             add_cout
);

   localparam int N    = WIDTH / NIB;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
   localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [NIB-1:0]   add_a_q, add_a_d;
   logic [NIB-1:0]   add_b_q, add_b_d;
   logic             add_cin_q, add_cin_d;
   logic             sub_s;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic r_msb);
      ovf_calc = (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

`ifdef ALU_SUB_EN
   assign sub_s = sub;
`else
   assign sub_s = 1'b0;
`endif

   // Next-state, operand capture and nibble accumulation.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               idx_d   = '0;
               acc_d   = '0;
               if (sub_s) begin
                  b_d     = ~b;
                  carry_d = 1'b1;
               end else begin
                  b_d     = b;
                  carry_d = cin;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            acc_d[NIB*idx_q +: NIB] = add_sum;
            carry_d = add_cout;
            // The final nibble publishes sum/cout/ovf together; idx parks at the last slot.
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               idx_d   = idx_q;
               sum_d   = acc_d;
               cout_d  = add_cout;
               ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], acc_d[WIDTH-1]);
            end else begin
               idx_d = idx_q + IDX_ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered status and slice drive, decoded from the state being entered.
   always_comb begin
      busy_d    = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
      if (state_d == ST_RUN) begin
         add_a_d   = a_d[NIB*idx_d +: NIB];
         add_b_d   = b_d[NIB*idx_d +: NIB];
         add_cin_d = carry_d;
      end else begin
         add_a_d   = '0;
         add_b_d   = '0;
         add_cin_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         sum_q     <= '0;
         idx_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         sum_q     <= sum_d;
         idx_q     <= idx_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         add_cin_q <= add_cin_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign sum     = sum_q;
   assign cout    = cout_q;
   assign ovf     = ovf_q;
   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign add_cin = add_cin_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: the adder slice is modelled here, expected results
// come from whole-word arithmetic and are checked when done is seen.
module tb_nibble_serial_add_ctrl;

   localparam int WIDTH = 32;
   localparam int N     = WIDTH / 4;
`ifdef ALU_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               dc;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             cin = 1'b0;
   logic             sub = 1'b0;
   logic             busy, done, cout, ovf, add_cin, add_cout;
   logic [WIDTH-1:0] sum;
   logic [3:0]       add_a, add_b, add_sum;

   exp_t             q[$];
   int               cyc = 0;
   int               last_e = -1000;
   int               n_chk = 0;
   int               n_fail = 0;
   int               n_done = 0;
   int               done_ref;
   logic [WIDTH-1:0] last_sum = '0;
   logic             last_cout = 1'b0;
   logic             last_ovf = 1'b0;

   nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ALU_SUB_EN
      .sub(sub),
`endif
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout)
   );

   // external 4-bit ripple slice
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic c, input logic s, input int dc);
      exp_t             e;
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] yy;
      logic             cc;
      yy     = (SUB_EN && s) ? ~y : y;
      cc     = (SUB_EN && s) ? 1'b1 : c;
      full   = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, cc};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (e.sum[WIDTH-1] != x[WIDTH-1]);
      e.dc   = dc;
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] pick();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b0, {(WIDTH-1){1'b1}}};
         3: v = {1'b1, {(WIDTH-1){1'b0}}};
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // One clock of stimulus; an op is expected only if the controller is idle or finishing.
   task automatic drive(input logic st, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic s);
      @(negedge clk);
      #1;
      start = st; a = x; b = y; cin = c; sub = s;
      if (st && rst_n && (cyc >= last_e + N)) begin
         q.push_back(model(x, y, c, s, cyc + 1 + N));
         last_e = cyc + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
   endtask

   task automatic monitor_step();
      logic be, de;
      exp_t e;
      be = rst_n && (cyc >= last_e) && (cyc < last_e + N);
      de = 1'b0;
      if (q.size() > 0) de = (q[0].dc == cyc);
      chk("busy", busy, be);
      chk("done", done, de);
      if (!be) begin
         chk("add_a_idle", add_a, 0);
         chk("add_b_idle", add_b, 0);
         chk("add_cin_idle", add_cin, 0);
      end
      if (done) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_no_op: done=1 with no pending op, expected done=0 (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("sum", sum, e.sum);
            chk("cout", cout, e.cout);
            chk("ovf", ovf, e.ovf);
            last_sum  = sum;
            last_cout = cout;
            last_ovf  = ovf;
            n_done++;
         end
      end else if (de) begin
         void'(q.pop_front());
      end
   endtask

   always @(negedge clk) monitor_step();

   task automatic check_result(input string nm, input logic [WIDTH-1:0] s, input logic c,
                               input logic o, input int nd);
      chk({nm, "_sum"}, last_sum, s);
      chk({nm, "_cout"}, last_cout, c);
      chk({nm, "_ovf"}, last_ovf, o);
      chk({nm, "_ndone"}, n_done, nd);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      drive(1'b1, 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0);
      idle(N + 2);
      check_result("t1", 32'h0000_0010, 1'b0, 1'b0, 1);

      drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      idle(N + 2);
      check_result("t2", 32'h0000_0000, 1'b1, 1'b0, 2);

      drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      idle(N + 2);
      check_result("t3", 32'h8000_0000, 1'b0, 1'b1, 3);
      done_ref = 3;

`ifdef ALU_SUB_EN
      drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b1);
      idle(N + 2);
      check_result("t4a", 32'hFFFF_FFFE, 1'b0, 1'b0, done_ref + 1);
      drive(1'b1, 32'd7, 32'd5, 1'b0, 1'b1);
      idle(N + 2);
      check_result("t4b", 32'h0000_0002, 1'b1, 1'b0, done_ref + 2);
      done_ref = done_ref + 2;
`endif

      // restart in RUN is dropped; restart on the DONE cycle is taken back to back
      drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      idle(2);
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      idle(N - 3);
      drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      idle(N + 2);
      check_result("t5", 32'h0000_0000, 1'b1, 1'b1, done_ref + 2);
      done_ref = done_ref + 2;

      // reset during RUN cycle 4
      drive(1'b1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      idle(3);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      start = 1'b0;
      q.delete();
      last_e = -1000;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_done", done, 0);
      chk("t6_sum", sum, 0);
      chk("t6_cout", cout, 0);
      chk("t6_ovf", ovf, 0);
      chk("t6_add_a", add_a, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      idle(2);
      chk("t6_no_done", n_done, done_ref);
      drive(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
      idle(N + 2);
      check_result("t6_fresh", 32'h0000_0004, 1'b0, 1'b0, done_ref + 1);

      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 2) == 0, pick(), pick(), 1'($urandom), 1'($urandom));
      idle(1);
      for (int i = 0; i < 4 * N && q.size() > 0; i++) idle(1);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d ops still pending, expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
